reset_sequencer: RTL

Parametrised power-up and recovery sequencer for the Ethernet front end. It synchronises N clock-generator lock flags and waits for them to be stable. It then drives a timed PHY hardware reset and releases a synchronous reset to the RGMII/parser logic in its own clock domain. On lock loss or software request it re-runs the sequence and counts lock-loss events for debug.

---
 rtl/reset_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Power-up / recovery sequencer: synchronises clock-generator lock flags, times the
// PHY hardware reset, then releases the clkIn-domain logic reset and counts lock losses.
module reset_sequencer #(
   parameter int NUM_LOCKS          = 2,
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int PHY_RST_CYCLES     = 1250000,
   parameter int PHY_WAKE_CYCLES    = 12500
) (
   input  logic                 clkIn,
   input  logic                 rstIn,
   input  logic [NUM_LOCKS-1:0] lockedIn,
   input  logic                 phyRstReqIn,
   output logic                 phyRstBOut,
   output logic                 rstOut,
   output logic                 readyOut,
   output logic [2:0]           stateOut,
   output logic [7:0]           lockLossCntOut
);

   typedef enum logic [2:0] {
      RESET     = 3'd0,
      WAIT_LOCK = 3'd1,
      PHY_RST   = 3'd2,
      PHY_WAKE  = 3'd3,
      RUN       = 3'd4
   } stateT;

   localparam int MAX_A   = (LOCK_STABLE_CYCLES > PHY_RST_CYCLES) ? LOCK_STABLE_CYCLES : PHY_RST_CYCLES;
   localparam int MAX_CYC = (MAX_A > PHY_WAKE_CYCLES) ? MAX_A : PHY_WAKE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PHYRST_LAST = CNT_W'(PHY_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAKE_LAST   = CNT_W'(PHY_WAKE_CYCLES - 1);

   // Saturating 8-bit increment for the debug lock-loss counter.
   function automatic logic [7:0] satInc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [NUM_LOCKS-1:0] syncR [SYNC_STAGES];
   logic                 allLockedS;
   stateT                stateR;
   stateT                stateNxtS;
   logic [CNT_W-1:0]     cntR;
   logic [CNT_W-1:0]     cntNxtS;
   logic                 lossS;
   logic [7:0]           lossCntR;
   logic                 phyRstBR;
   logic                 rstR;
   logic                 readyR;
   logic                 phyRstBNxtS;
   logic                 rstNxtS;
   logic                 readyNxtS;

   // Lock-flag synchroniser chains, one stage per row, all lock bits in parallel.
   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            syncR[i] <= '0;
         end
      end else begin
         syncR[0] <= lockedIn;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            syncR[i] <= syncR[i-1];
         end
      end
   end

   assign allLockedS = &syncR[SYNC_STAGES-1];

   // Next-state, shared counter and lock-loss detection.
   always_comb begin
      stateNxtS = stateR;
      cntNxtS   = '0;
      lossS     = 1'b0;
      case (stateR)
         RESET: begin
            stateNxtS = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (!allLockedS) begin
               cntNxtS = '0;
            end else if (cntR == STABLE_LAST) begin
               stateNxtS = PHY_RST;
            end else begin
               cntNxtS = cntR + CNT_ONE;
            end
         end
         PHY_RST: begin
            if (!allLockedS) begin
               lossS     = 1'b1;
               stateNxtS = WAIT_LOCK;
            end else if (cntR == PHYRST_LAST) begin
               stateNxtS = PHY_WAKE;
            end else begin
               cntNxtS = cntR + CNT_ONE;
            end
         end
         PHY_WAKE: begin
            if (!allLockedS) begin
               lossS     = 1'b1;
               stateNxtS = WAIT_LOCK;
            end else if (cntR == WAKE_LAST) begin
               stateNxtS = RUN;
            end else begin
               cntNxtS = cntR + CNT_ONE;
            end
         end
         RUN: begin
            // Lock loss wins over a simultaneous software re-reset request.
            if (!allLockedS) begin
               lossS     = 1'b1;
               stateNxtS = WAIT_LOCK;
            end else if (phyRstReqIn) begin
               stateNxtS = PHY_RST;
            end else begin
               stateNxtS = RUN;
            end
         end
         default: begin
            stateNxtS = RESET;
         end
      endcase
   end

   // Output decode from the next state so outputs move on the same edge as stateOut.
   always_comb begin
      phyRstBNxtS = 1'b0;
      rstNxtS     = 1'b1;
      readyNxtS   = 1'b0;
      case (stateNxtS)
         PHY_WAKE: begin
            phyRstBNxtS = 1'b1;
         end
         RUN: begin
            phyRstBNxtS = 1'b1;
            rstNxtS     = 1'b0;
            readyNxtS   = 1'b1;
         end
         default: begin
            phyRstBNxtS = 1'b0;
         end
      endcase
   end

   // State, counter, lock-loss count and registered outputs.
   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         stateR   <= RESET;
         cntR     <= '0;
         lossCntR <= 8'd0;
         phyRstBR <= 1'b0;
         rstR     <= 1'b1;
         readyR   <= 1'b0;
      end else begin
         stateR   <= stateNxtS;
         cntR     <= cntNxtS;
         lossCntR <= lossS ? satInc(lossCntR) : lossCntR;
         phyRstBR <= phyRstBNxtS;
         rstR     <= rstNxtS;
         readyR   <= readyNxtS;
      end
   end

   assign stateOut       = stateR;
   assign lockLossCntOut = lossCntR;
   assign phyRstBOut     = phyRstBR;
   assign rstOut         = rstR;
   assign readyOut       = readyR;

endmodule
